// File: rtl/rom_fetch_unit_pkg.sv
// Shared constants and types for the ROM fetch path.
//   ADDR_W / DATA_W : ROM address and byte widths
//   ROM_DEPTH       : number of valid ROM locations (0..ROM_DEPTH-1)
//   RESET_PC        : program counter value after reset
//   fetch_entry_t   : one prefetched byte tagged with its ROM address
package mem_sys_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int ROM_DEPTH = 128;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_unit_if.sv
// Byte stream from the fetch unit to the decode stage (valid/ready).
//   byte_valid : head of the prefetch queue is valid
//   byte_data  : head byte
//   byte_addr  : ROM address of the head byte
//   byte_ready : consumer takes the head this cycle
// master = fetch unit (producer), slave = decode stage (consumer).
interface rom_fetch_unit_if;
    import mem_sys_pkg::*;

    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic [ADDR_W-1:0] byte_addr;
    logic              byte_ready;

    modport master (output byte_valid, byte_data, byte_addr, input byte_ready);
    modport slave  (input byte_valid, byte_data, byte_addr, output byte_ready);
endinterface

// File: rtl/rom_fetch_unit_queue.sv
// fetch_queue: synchronous circular FIFO of fetch_entry_t.
//   clk, rst_n      : clock, async active-low reset
//   push/push_entry : write an entry at the tail
//   pop             : advance the head (caller guarantees non-empty)
//   flush           : empty the queue; overrides push and pop
//   head            : head entry, forced to zero while empty
//   count           : number of valid entries (0..QDEPTH)
module fetch_queue
    import mem_sys_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(QDEPTH):0]  count
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    // Storage is not reset, so mask the head to keep outputs clean when empty.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !pop && count == CNT_W'(QDEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && count == '0));

endmodule

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: sequential byte fetcher in front of the registered 128x8 ROM.
//   clk, rst_n        : clock, async active-low reset
//   rom_address       : ROM address, straight from the PC flop
//   rom_data_in       : ROM read data, valid one cycle after the address
//   fetch_en          : permits new ROM reads
//   redirect_valid/addr : one-cycle jump request with flush
//   byte_if (master)  : valid/ready byte stream to decode
//   fault             : sticky, fetch attempted past the end of ROM
// Address/data widths come from mem_sys_pkg because the queue entry struct
// is defined there.
module rom_fetch_unit
    import mem_sys_pkg::*;
#(
    parameter int                QDEPTH    = 4,
    parameter int                ROM_DEPTH = mem_sys_pkg::ROM_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = mem_sys_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_W-1:0]     rom_address,
    input  logic [DATA_W-1:0]     rom_data_in,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_addr,
    rom_fetch_unit_if.master      byte_if,
    output logic                  fault
);
    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        pend_addr;
    logic                     rd_pending;
    logic [$clog2(QDEPTH):0]  count;
    fetch_entry_t             head;
    fetch_entry_t             push_entry;
    logic                     pc_in_rom;
    logic                     credit_ok;
    logic                     issue;
    logic                     fault_set;
    logic                     push;
    logic                     pop;

    assign pc_in_rom = int'(pc) < ROM_DEPTH;
    // Reserve a slot for the in-flight byte; a same-cycle pop is not credited.
    assign credit_ok = (int'(count) + int'(rd_pending)) < QDEPTH;
    assign issue     = fetch_en && !redirect_valid && !fault && pc_in_rom && credit_ok;
    assign fault_set = fetch_en && !redirect_valid && !fault && !pc_in_rom;

    // Redirect discards the in-flight byte and freezes the consumer side.
    assign push       = rd_pending && !redirect_valid;
    assign pop        = byte_if.byte_valid && byte_if.byte_ready && !redirect_valid;
    assign push_entry = '{addr: pend_addr, data: rom_data_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            pend_addr  <= '0;
            rd_pending <= 1'b0;
            fault      <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= redirect_addr;
            rd_pending <= 1'b0;
            fault      <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                pc        <= pc + 1'b1;
                pend_addr <= pc;
            end
            if (fault_set) fault <= 1'b1;
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign rom_address        = pc;
    assign byte_if.byte_valid = (count != '0);
    assign byte_if.byte_data  = head.data;
    assign byte_if.byte_addr  = head.addr;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: directed scenarios plus a random
// stream checked against an in-order address/data model of the ROM.
module tb_rom_fetch_unit;
    import mem_sys_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data_in;
    logic              fetch_en = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              fault;

    int tests = 0;
    int fails = 0;

    logic [7:0] rom [128];
    logic [7:0] prog [6];

    rom_fetch_unit_if bif ();

    rom_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address),
        .rom_data_in    (rom_data_in),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .byte_if        (bif),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // Registered-read ROM model.
    always @(posedge clk) rom_data_in <= rom[rom_address[6:0]];

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic fe, input logic br);
        @(posedge clk); #2;
        rst_n = 1'b0;
        fetch_en = fe;
        bif.byte_ready = br;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b0, 1'b0);
        tick();
        tests++; if (bif.byte_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bif.byte_valid); end
        tests++; if (bif.byte_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", bif.byte_data); end
        tests++; if (bif.byte_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want 00", bif.byte_addr); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", fault); end
        tests++; if (rom_address !== 8'h00) begin fails++; $display("FAIL reset_rom_address got %h want 00", rom_address); end
    endtask

    task automatic test_stream();
        apply_reset(1'b1, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                tests++; if (bif.byte_valid !== 1'b0) begin fails++; $display("FAIL stream_first_edge valid got %b want 0", bif.byte_valid); end
            end else begin
                tests++;
                if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'(c-2) || bif.byte_data !== prog[c-2]) begin
                    fails++;
                    $display("FAIL stream_byte%0d got v=%b a=%h d=%h want v=1 a=%h d=%h",
                             c-2, bif.byte_valid, bif.byte_addr, bif.byte_data, 8'(c-2), prog[c-2]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        apply_reset(1'b1, 1'b0);
        repeat (8) tick();
        tests++;
        if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'h00 || bif.byte_data !== 8'h86) begin
            fails++; $display("FAIL bp_head got v=%b a=%h d=%h want v=1 a=00 d=86", bif.byte_valid, bif.byte_addr, bif.byte_data);
        end
        tests++; if (rom_address !== 8'h04) begin fails++; $display("FAIL bp_pc got %h want 04", rom_address); end
        repeat (4) tick();
        tests++; if (rom_address !== 8'h04) begin fails++; $display("FAIL bp_pc_hold got %h want 04", rom_address); end
        bif.byte_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 16 && got < 5; c++) begin
            if (bif.byte_valid && bif.byte_ready) begin
                tests++;
                if (bif.byte_addr !== 8'(got) || bif.byte_data !== rom[got]) begin
                    fails++; $display("FAIL bp_drain%0d got a=%h d=%h want a=%h d=%h", got, bif.byte_addr, bif.byte_data, 8'(got), rom[got]);
                end
                got++;
            end
            tick();
        end
        tests++; if (got != 5) begin fails++; $display("FAIL bp_drain_timeout got %0d bytes want 5", got); end
    endtask

    task automatic test_redirect();
        int got;
        apply_reset(1'b1, 1'b0);
        repeat (4) tick();   // three bytes queued, address 3 in flight
        redirect_valid = 1'b1;
        redirect_addr = 8'h02;
        bif.byte_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tests++; if (bif.byte_valid !== 1'b0) begin fails++; $display("FAIL redir_flush valid got %b want 0", bif.byte_valid); end
        tests++; if (rom_address !== 8'h02) begin fails++; $display("FAIL redir_pc got %h want 02", rom_address); end
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (bif.byte_valid && bif.byte_ready) begin
                tests++;
                if (bif.byte_addr !== 8'(2+got) || bif.byte_data !== rom[2+got]) begin
                    fails++; $display("FAIL redir_byte%0d got a=%h d=%h want a=%h d=%h", got, bif.byte_addr, bif.byte_data, 8'(2+got), rom[2+got]);
                end
                got++;
            end
            tick();
        end
        tests++; if (got != 3) begin fails++; $display("FAIL redir_timeout got %0d bytes want 3", got); end
    endtask

    task automatic test_fault();
        apply_reset(1'b1, 1'b1);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_addr = 8'h7E;
        tick();
        redirect_valid = 1'b0;
        tick();
        tests++; if (bif.byte_valid !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL fault_a got v=%b f=%b want v=0 f=0", bif.byte_valid, fault); end
        tick();
        tests++;
        if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'h7E || bif.byte_data !== rom[126] || fault !== 1'b0 || rom_address !== 8'h80) begin
            fails++; $display("FAIL fault_b got v=%b a=%h d=%h f=%b pc=%h want v=1 a=7e d=%h f=0 pc=80", bif.byte_valid, bif.byte_addr, bif.byte_data, fault, rom_address, rom[126]);
        end
        tick();
        tests++;
        if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'h7F || bif.byte_data !== rom[127] || fault !== 1'b1) begin
            fails++; $display("FAIL fault_c got v=%b a=%h d=%h f=%b want v=1 a=7f d=%h f=1", bif.byte_valid, bif.byte_addr, bif.byte_data, fault, rom[127]);
        end
        repeat (4) tick();
        tests++;
        if (bif.byte_valid !== 1'b0 || fault !== 1'b1 || rom_address !== 8'h80) begin
            fails++; $display("FAIL fault_hold got v=%b f=%b pc=%h want v=0 f=1 pc=80", bif.byte_valid, fault, rom_address);
        end
        redirect_valid = 1'b1;
        redirect_addr = 8'h00;
        tick();
        redirect_valid = 1'b0;
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_clear got %b want 0", fault); end
        repeat (2) tick();
        tests++;
        if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'h00 || bif.byte_data !== 8'h86) begin
            fails++; $display("FAIL fault_restart got v=%b a=%h d=%h want v=1 a=00 d=86", bif.byte_valid, bif.byte_addr, bif.byte_data);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b1, 1'b1);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bif.byte_valid !== 1'b0 || fault !== 1'b0 || rom_address !== 8'h00 || bif.byte_addr !== 8'h00) begin
            fails++; $display("FAIL async_reset got v=%b f=%b pc=%h a=%h want 0 0 00 00", bif.byte_valid, fault, rom_address, bif.byte_addr);
        end
        #3;
        rst_n = 1'b1;
        tick();
        tests++; if (bif.byte_valid !== 1'b0) begin fails++; $display("FAIL async_restart_edge1 valid got %b want 0", bif.byte_valid); end
        tick();
        tests++;
        if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'h00 || bif.byte_data !== 8'h86) begin
            fails++; $display("FAIL async_restart got v=%b a=%h d=%h want v=1 a=00 d=86", bif.byte_valid, bif.byte_addr, bif.byte_data);
        end
    endtask

    task automatic test_fetch_gap();
        apply_reset(1'b1, 1'b1);
        tick();              // address 0 issued
        fetch_en = 1'b0;
        tick();
        tests++;
        if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'h00 || bif.byte_data !== 8'h86) begin
            fails++; $display("FAIL gap_inflight got v=%b a=%h d=%h want v=1 a=00 d=86", bif.byte_valid, bif.byte_addr, bif.byte_data);
        end
        fetch_en = 1'b1;
        tick();
        tests++; if (bif.byte_valid !== 1'b0) begin fails++; $display("FAIL gap_bubble valid got %b want 0", bif.byte_valid); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests++;
            if (bif.byte_valid !== 1'b1 || bif.byte_addr !== 8'(k) || bif.byte_data !== rom[k]) begin
                fails++; $display("FAIL gap_seq%0d got v=%b a=%h d=%h want v=1 a=%h d=%h", k, bif.byte_valid, bif.byte_addr, bif.byte_data, 8'(k), rom[k]);
            end
        end
    endtask

    // Model: after each redirect to T, delivered bytes are T, T+1, ... in order
    // with data from the ROM image, never past the ROM end, and the queue is
    // empty the cycle after a redirect.
    task automatic test_random();
        int  exp_next;
        bit  expect_empty;
        bit  seen;
        int  t;
        apply_reset(1'b1, 1'b1);
        exp_next = 0;
        expect_empty = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (expect_empty) begin
                tests++; if (bif.byte_valid !== 1'b0) begin fails++; $display("FAIL rnd_flush@%0d valid got %b want 0", i, bif.byte_valid); end
            end
            expect_empty = 1'b0;
            fetch_en       = ($urandom % 8) != 0;
            bif.byte_ready = ($urandom % 4) != 0;
            if (($urandom % 64) == 0) begin
                t = (($urandom % 3) == 0) ? 120 + int'($urandom % 8) : int'($urandom % 128);
                redirect_valid = 1'b1;
                redirect_addr  = 8'(t);
                exp_next = t;
                expect_empty = 1'b1;
            end else begin
                redirect_valid = 1'b0;
                if (bif.byte_valid && bif.byte_ready) begin
                    tests++;
                    if (exp_next >= 128 || bif.byte_addr !== 8'(exp_next) || bif.byte_data !== rom[exp_next[6:0]]) begin
                        fails++; $display("FAIL rnd_byte@%0d got a=%h d=%h want a=%h", i, bif.byte_addr, bif.byte_data, 8'(exp_next));
                    end
                    exp_next++;
                end
            end
            tick();
        end
        fetch_en = 1'b1;
        bif.byte_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 8'h10;
        tick();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            seen = bif.byte_valid;
        end
        tests++;
        if (!seen || bif.byte_addr !== 8'h10 || bif.byte_data !== rom[16]) begin
            fails++; $display("FAIL rnd_resume got v=%b a=%h d=%h want v=1 a=10 d=%h", seen, bif.byte_addr, bif.byte_data, rom[16]);
        end
    endtask

    initial begin
        prog[0] = 8'h86; prog[1] = 8'hAA; prog[2] = 8'h96;
        prog[3] = 8'hE0; prog[4] = 8'h20; prog[5] = 8'h00;
        for (int i = 0; i < 128; i++) rom[i] = (i < 6) ? prog[i] : 8'($urandom);
        bif.byte_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_async_reset();
        test_fetch_gap();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
